// File: rtl/fu_arbiter.sv
// rtl/fu_arbiter.sv - round-robin arbiter sharing one 16-bit function unit
// Accepts one op at a time, holds FU operands in registers and returns f/z/n to the issuer.
module fu_arbiter #(
   parameter int NREQ    = 2,
   parameter int MUL_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid_in,
   output logic [NREQ-1:0]      req_ready_out,
   input  logic [NREQ*16-1:0]   req_a_in,
   input  logic [NREQ*16-1:0]   req_b_in,
   input  logic [NREQ*4-1:0]    req_fs_in,
   output logic [NREQ-1:0]      rsp_valid_out,
   input  logic [NREQ-1:0]      rsp_ready_in,
   output logic [15:0]          rsp_f_out,
   output logic                 rsp_z_out,
   output logic                 rsp_n_out,
   output logic [15:0]          fu_a_out,
   output logic [15:0]          fu_b_out,
   output logic [3:0]           fu_fs_out,
   input  logic [15:0]          fu_f_in,
   input  logic                 fu_z_in,
   input  logic                 fu_n_in,
   output logic                 busy_out
);

   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(MUL_LAT + 1);
   localparam logic [3:0] FS_FMUL = 4'b0011;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t          state_q;
   logic [GW-1:0]   rr_q;
   logic [GW-1:0]   gnt_q;
   logic [CW-1:0]   cnt_q;
   logic [NREQ-1:0] rsp_valid_q;
   logic [15:0]     fu_a_q;
   logic [15:0]     fu_b_q;
   logic [3:0]      fu_fs_q;
   logic [15:0]     rsp_f_q;
   logic            rsp_z_q;
   logic            rsp_n_q;

   logic [GW-1:0]   gnt_idx;
   logic            gnt_found;
   logic [15:0]     sel_a;
   logic [15:0]     sel_b;
   logic [3:0]      sel_fs;
   logic [NREQ-1:0] gnt_onehot;
   logic [GW-1:0]   rr_d;

   // Search starts at the rr pointer so the last served requester goes to the back.
   always_comb begin
      int          k;
      logic [GW-1:0] kk;
      k         = 0;
      kk        = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         k  = (int'(rr_q) + i) % NREQ;
         kk = GW'(k);
         if (!gnt_found && req_valid_in[kk]) begin
            gnt_found = 1'b1;
            gnt_idx   = kk;
         end
      end
   end

   always_comb begin
      sel_a         = '0;
      sel_b         = '0;
      sel_fs        = '0;
      req_ready_out = '0;
      gnt_onehot    = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (gnt_idx == GW'(j)) begin
            sel_a  = req_a_in[j*16 +: 16];
            sel_b  = req_b_in[j*16 +: 16];
            sel_fs = req_fs_in[j*4 +: 4];
         end
         req_ready_out[j] = (state_q == S_IDLE) && !rst && gnt_found && (gnt_idx == GW'(j));
         gnt_onehot[j]    = (gnt_q == GW'(j));
      end
      rr_d = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         gnt_q       <= '0;
         cnt_q       <= '0;
         rsp_valid_q <= '0;
         fu_a_q      <= '0;
         fu_b_q      <= '0;
         fu_fs_q     <= '0;
         rsp_f_q     <= '0;
         rsp_z_q     <= 1'b0;
         rsp_n_q     <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (gnt_found) begin
                  fu_a_q  <= sel_a;
                  fu_b_q  <= sel_b;
                  fu_fs_q <= sel_fs;
                  gnt_q   <= gnt_idx;
                  cnt_q   <= (sel_fs == FS_FMUL) ? CW'(MUL_LAT) : CW'(1);
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (cnt_q == CW'(1)) begin
                  rsp_f_q     <= fu_f_in;
                  rsp_z_q     <= fu_z_in;
                  rsp_n_q     <= fu_n_in;
                  rsp_valid_q <= gnt_onehot;
                  cnt_q       <= '0;
                  state_q     <= S_RESP;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_in[gnt_q]) begin
                  rsp_valid_q <= '0;
                  rr_q        <= rr_d;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid_out = rsp_valid_q;
   assign rsp_f_out     = rsp_f_q;
   assign rsp_z_out     = rsp_z_q;
   assign rsp_n_out     = rsp_n_q;
   assign fu_a_out      = fu_a_q;
   assign fu_b_out      = fu_b_q;
   assign fu_fs_out     = fu_fs_q;
   assign busy_out      = (state_q != S_IDLE);

endmodule
